// File: rtl/shift_pipe_if.sv
// Handshake bundle for shift_pipe: operand beat in, result beat out.
// The master modport is the producer/consumer side; the slave modport is the shifter.
interface shift_pipe_if #(
    parameter int WIDTH = 16,
    parameter int LOG2W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [LOG2W-1:0] in_shamt;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_cout;
    logic             out_zero;
    logic             out_err;

    modport master (
        output in_valid, in_data, in_shamt, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_cout, out_zero, out_err
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, out_ready,
        output in_ready, out_valid, out_data, out_cout, out_zero, out_err
    );
endinterface

// File: rtl/shift_pipe.sv
// Barrel shifter/rotator built from LOG2W power-of-two stages, either registered after
// every stage or collapsed into a single output register, with valid/ready on both sides.
module shift_pipe #(
    parameter int WIDTH     = 16,
    parameter int LOG2W     = 4,
    parameter bit PIPELINED = 1
) (
    input  logic         clk,
    input  logic         rst,
    shift_pipe_if.slave  bus
);
    localparam int LAST = LOG2W - 1;

    localparam logic [2:0] OP_ROL = 3'b000;
    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    function automatic logic [WIDTH-1:0] stage_shift(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       op,
        input logic [LOG2W-1:0] sh,
        input int               k
    );
        logic [WIDTH-1:0] r;
        logic [LOG2W-1:0] s;
        int               amt;
        r   = d;
        s   = sh >> k;
        amt = 1 << k;
        if (s[0]) begin
            case (op)
                OP_ROL:  r = (d << amt) | (d >> (WIDTH - amt));
                OP_SLL:  r = d << amt;
                OP_SRA:  r = $signed(d) >>> amt;
                OP_SRL:  r = d >> amt;
                OP_ROR:  r = (d >> amt) | (d << (WIDTH - amt));
                default: r = d;
            endcase
        end
        return r;
    endfunction

    // Carry-out depends only on the original operand, so it is resolved once at the input.
    function automatic logic calc_cout(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       op,
        input logic [LOG2W-1:0] sh
    );
        logic [WIDTH-1:0] t;
        logic             c;
        int               n;
        n = int'(sh);
        c = 1'b0;
        t = '0;
        if (n != 0) begin
            case (op)
                OP_SLL: begin
                    t = d >> (WIDTH - n);
                    c = t[0];
                end
                OP_SRA, OP_SRL: begin
                    t = d >> (n - 1);
                    c = t[0];
                end
                default: c = 1'b0;
            endcase
        end
        return c;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < LOG2W; gi++) begin : g_stage
            localparam bit REG = (PIPELINED != 0) || (gi == LAST);

            logic             v_in;
            logic             c_in;
            logic [WIDTH-1:0] d_in;
            logic [WIDTH-1:0] d_sh;
            logic [2:0]       op_in;
            logic [LOG2W-1:0] sh_in;
            logic             v_o;
            logic             c_o;
            logic [WIDTH-1:0] d_o;
            logic [2:0]       op_o;
            logic             rdy_i;
            logic             rdy_o;

            if (gi == 0) begin : g_src
                assign v_in  = bus.in_valid;
                assign d_in  = bus.in_data;
                assign op_in = bus.in_op;
                assign sh_in = bus.in_shamt;
                assign c_in  = calc_cout(bus.in_data, bus.in_op, bus.in_shamt);
            end else begin : g_src
                assign v_in  = g_stage[gi-1].v_o;
                assign d_in  = g_stage[gi-1].d_o;
                assign op_in = g_stage[gi-1].op_o;
                assign sh_in = g_stage[gi-1].g_fwd.sh_o;
                assign c_in  = g_stage[gi-1].c_o;
            end

            if (gi == LAST) begin : g_rdy
                assign rdy_i = bus.out_ready;
            end else begin : g_rdy
                assign rdy_i = g_stage[gi+1].rdy_o;
            end

            assign d_sh = stage_shift(d_in, op_in, sh_in, gi);

            if (REG) begin : g_reg
                logic             v_q, v_d;
                logic             c_q, c_d;
                logic [WIDTH-1:0] d_q, d_d;
                logic [2:0]       op_q, op_d;

                // An empty stage always loads, which is what lets bubbles collapse.
                assign rdy_o = !v_q || rdy_i;

                always_comb begin
                    v_d  = v_q;
                    c_d  = c_q;
                    d_d  = d_q;
                    op_d = op_q;
                    if (rdy_o) begin
                        v_d = v_in;
                        if (v_in) begin
                            c_d  = c_in;
                            d_d  = d_sh;
                            op_d = op_in;
                        end
                    end
                end

                always_ff @(posedge clk) begin
                    if (rst) begin
                        v_q  <= 1'b0;
                        c_q  <= 1'b0;
                        d_q  <= '0;
                        op_q <= '0;
                    end else begin
                        v_q  <= v_d;
                        c_q  <= c_d;
                        d_q  <= d_d;
                        op_q <= op_d;
                    end
                end

                assign v_o  = v_q;
                assign c_o  = c_q;
                assign d_o  = d_q;
                assign op_o = op_q;
            end else begin : g_thru
                assign rdy_o = rdy_i;
                assign v_o   = v_in;
                assign c_o   = c_in;
                assign d_o   = d_sh;
                assign op_o  = op_in;
            end

            // The final stage has no successor, so it never needs the shift amount again.
            if (gi < LAST) begin : g_fwd
                logic [LOG2W-1:0] sh_o;
                if (REG) begin : g_sh_reg
                    logic [LOG2W-1:0] sh_q, sh_d;
                    always_comb begin
                        sh_d = sh_q;
                        if (rdy_o && v_in) begin
                            sh_d = sh_in;
                        end
                    end
                    always_ff @(posedge clk) begin
                        if (rst) begin
                            sh_q <= '0;
                        end else begin
                            sh_q <= sh_d;
                        end
                    end
                    assign sh_o = sh_q;
                end else begin : g_sh_thru
                    assign sh_o = sh_in;
                end
            end
        end
    endgenerate

    logic zero_q, zero_d;

    always_comb begin
        zero_d = zero_q;
        if (g_stage[LAST].rdy_o && g_stage[LAST].v_in) begin
            zero_d = (g_stage[LAST].d_sh == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign bus.in_ready  = g_stage[0].rdy_o;
    assign bus.out_valid = g_stage[LAST].v_o;
    assign bus.out_data  = g_stage[LAST].d_o;
    assign bus.out_cout  = g_stage[LAST].c_o;
    assign bus.out_zero  = zero_q;
    assign bus.out_err   = (g_stage[LAST].op_o > OP_ROR);
endmodule

// File: tb/tb_shift_pipe.sv
// Scoreboard bench for shift_pipe: the driver queues hand-computed results on acceptance,
// a monitor pops and compares whenever a result beat is consumed.
module tb_shift_pipe;
    localparam int W     = 16;
    localparam int L     = 4;
    localparam bit PIPE  = 1;
    localparam int DEPTH = PIPE ? L : 1;

    typedef struct packed {
        logic [2:0]   op;
        logic [L-1:0] sh;
        logic [W-1:0] d;
        logic [W-1:0] e;
        logic         c;
        logic         err;
    } vec_t;

    typedef struct {
        logic [W-1:0] d;
        logic         c;
        logic         z;
        logic         e;
        int           acc;
        bit           lat;
        int           id;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shift_pipe_if #(.WIDTH(W), .LOG2W(L)) sp_if ();

    shift_pipe #(.WIDTH(W), .LOG2W(L), .PIPELINED(PIPE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sp_if)
    );

    exp_t        sb[$];
    vec_t        vecs[22];
    int          total    = 0;
    int          bad      = 0;
    int          cyc      = 0;
    int          rdy_mode = 0;
    bit          lat_chk  = 1'b0;
    logic [12:0] pat      = 13'b1011001110100;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic try_send(input vec_t v, input int id, output bit acc);
        exp_t x;
        sp_if.in_valid = 1'b1;
        sp_if.in_op    = v.op;
        sp_if.in_shamt = v.sh;
        sp_if.in_data  = v.d;
        @(negedge clk);
        acc = sp_if.in_ready && !rst;
        if (acc) begin
            x.d   = v.e;
            x.c   = v.c;
            x.z   = (v.e == '0);
            x.e   = v.err;
            x.acc = cyc;
            x.lat = lat_chk;
            x.id  = id;
            sb.push_back(x);
            $display("send id=%0d op=%0d sh=%0d data=%h expect=%h cout=%0b err=%0b",
                     id, v.op, v.sh, v.d, v.e, v.c, v.err);
        end
        @(posedge clk);
        #1;
        sp_if.in_valid = 1'b0;
    endtask

    task automatic send(input vec_t v, input int id);
        bit a;
        int n;
        n = 0;
        a = 1'b0;
        while (!a && n < 300) begin
            try_send(v, id, a);
            n++;
        end
        if (!a) check("send_timeout", a, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    endtask

    // Monitor: compares consumed beats, latency when requested, and stability under stall.
    initial begin : monitor
        exp_t         e;
        bit           held;
        logic [W+2:0] held_val;
        logic [W+2:0] cur;
        held = 1'b0;
        held_val = '0;
        forever begin
            @(negedge clk);
            cur = {sp_if.out_data, sp_if.out_cout, sp_if.out_zero, sp_if.out_err};
            if (rst) begin
                held = 1'b0;
            end else begin
                if (held && sp_if.out_valid) check("hold_while_stalled", cur, held_val);
                if (sp_if.out_valid && sp_if.out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_beat", sp_if.out_valid, 0);
                    end else begin
                        e = sb.pop_front();
                        $display("recv id=%0d data=%h cout=%0b zero=%0b err=%0b",
                                 e.id, sp_if.out_data, sp_if.out_cout, sp_if.out_zero, sp_if.out_err);
                        check($sformatf("beat id=%0d {data,cout,zero,err}", e.id), cur,
                              {e.d, e.c, e.z, e.e});
                        if (e.lat) check($sformatf("latency id=%0d", e.id), cyc - e.acc, DEPTH);
                    end
                end
                held     = sp_if.out_valid && !sp_if.out_ready;
                held_val = cur;
            end
        end
    end

    // Pseudo-random-looking but fixed back-pressure pattern for the stall phase.
    initial begin : ready_gen
        forever begin
            @(posedge clk);
            #2;
            if (rdy_mode == 1) sp_if.out_ready = pat[4'(cyc % 13)];
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit a;
        int n;
        //                op     sh     data      expect    c     err
        vecs[0]  = '{3'd0, 4'd1,  16'h8001, 16'h0003, 1'b0, 1'b0};
        vecs[1]  = '{3'd4, 4'd1,  16'h0001, 16'h8000, 1'b0, 1'b0};
        vecs[2]  = '{3'd2, 4'd4,  16'h8000, 16'hF800, 1'b0, 1'b0};
        vecs[3]  = '{3'd3, 4'd15, 16'h8000, 16'h0001, 1'b0, 1'b0};
        vecs[4]  = '{3'd1, 4'd8,  16'h01FF, 16'hFF00, 1'b1, 1'b0};
        vecs[5]  = '{3'd1, 4'd0,  16'h0001, 16'h0001, 1'b0, 1'b0};
        vecs[6]  = '{3'd3, 4'd1,  16'h0001, 16'h0000, 1'b1, 1'b0};
        vecs[7]  = '{3'd7, 4'd5,  16'h1234, 16'h1234, 1'b0, 1'b1};
        vecs[8]  = '{3'd0, 4'd4,  16'h1234, 16'h2341, 1'b0, 1'b0};
        vecs[9]  = '{3'd4, 4'd8,  16'h1234, 16'h3412, 1'b0, 1'b0};
        vecs[10] = '{3'd2, 4'd8,  16'h7F00, 16'h007F, 1'b0, 1'b0};
        vecs[11] = '{3'd2, 4'd1,  16'h8421, 16'hC210, 1'b1, 1'b0};
        vecs[12] = '{3'd1, 4'd1,  16'hC000, 16'h8000, 1'b1, 1'b0};
        vecs[13] = '{3'd3, 4'd4,  16'hABCD, 16'h0ABC, 1'b1, 1'b0};
        vecs[14] = '{3'd0, 4'd15, 16'hABCD, 16'hD5E6, 1'b0, 1'b0};
        vecs[15] = '{3'd5, 4'd3,  16'h0000, 16'h0000, 1'b0, 1'b1};
        vecs[16] = '{3'd1, 4'd15, 16'hFFFF, 16'h8000, 1'b1, 1'b0};
        vecs[17] = '{3'd2, 4'd15, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0};
        vecs[18] = '{3'd4, 4'd4,  16'h00F0, 16'h000F, 1'b0, 1'b0};
        vecs[19] = '{3'd0, 4'd7,  16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[20] = '{3'd4, 4'd0,  16'h5A5A, 16'h5A5A, 1'b0, 1'b0};
        vecs[21] = '{3'd3, 4'd0,  16'h8000, 16'h8000, 1'b0, 1'b0};

        sp_if.in_valid  = 1'b0;
        sp_if.in_data   = '0;
        sp_if.in_shamt  = '0;
        sp_if.in_op     = '0;
        sp_if.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset out_valid", sp_if.out_valid, 0);
        check("reset out_data",  sp_if.out_data, 0);
        check("reset out_cout",  sp_if.out_cout, 0);
        check("reset out_zero",  sp_if.out_zero, 0);
        check("reset out_err",   sp_if.out_err, 0);
        check("reset in_ready",  sp_if.in_ready, 1);
        @(posedge clk);
        #1;

        // Back-to-back directed vectors, no back-pressure: full rate and fixed latency
        lat_chk = 1'b1;
        for (int i = 0; i < 22; i++) begin
            try_send(vecs[i], i, a);
            check($sformatf("full_rate accept id=%0d", i), a, 1);
        end
        drain();
        lat_chk = 1'b0;

        // Same vectors with gaps and a toggling out_ready
        rdy_mode = 1;
        for (int i = 0; i < 22; i++) begin
            send(vecs[i], 100 + i);
            if (i % 3 == 2) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        rdy_mode = 0;
        sp_if.out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Fill with out_ready low, then release and count drain cycles
        sp_if.out_ready = 1'b0;
        n = 0;
        for (int i = 0; i < L + 3; i++) begin
            try_send(vecs[i + 8], 200 + i, a);
            n += int'(a);
        end
        check("fill accepted beats", n, DEPTH);
        @(negedge clk);
        check("fill in_ready", sp_if.in_ready, 0);
        @(posedge clk);
        #1;
        sp_if.out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain cycles", n, DEPTH);

        // Reset with beats in flight; in_valid held high throughout reset
        sp_if.out_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            try_send(vecs[i + 2], 300 + i, a);
            n += int'(a);
        end
        check("beats in flight before reset", n, PIPE ? 3 : 1);
        rst = 1'b1;
        sb.delete();
        sp_if.in_valid = 1'b1;
        sp_if.in_op    = 3'd1;
        sp_if.in_shamt = 4'd1;
        sp_if.in_data  = 16'hFFFF;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("out_valid after reset edge", sp_if.out_valid, 0);
        @(posedge clk);
        #1;
        sp_if.in_valid  = 1'b0;
        rst             = 1'b0;
        sp_if.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("no stale beat %0d", i), sp_if.out_valid, 0);
        end
        @(posedge clk);
        #1;

        // Recovery after reset
        for (int i = 0; i < 4; i++) send(vecs[i + 14], 400 + i);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
